// File: rtl/norm_round_pipe_if.sv
// Handshake and payload bundle for the normalise/round pipeline.
// master = producer/consumer side (testbench or datapath), slave = the pipeline.
interface norm_round_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = MAN_W + 5;

    // Both sides use valid/ready: a beat moves on a rising edge where valid && ready;
    // the sender holds the payload stable while valid is high and ready is low.
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_sign;
    logic [EXP_W-1:0]       in_exp;
    logic [W-1:0]           in_frac;
    logic [1:0]             rnd_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   out_result;
    logic [3:0]             out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_frac, rnd_mode, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_frac, rnd_mode, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/norm_round_pipe.sv
// Three-stage post-add normaliser: leading-one detect, shift/exponent adjust,
// then round, renormalise and pack with IEEE-754 exception flags.
module norm_round_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic               clk,
    input  logic               rst_n,
    norm_round_pipe_if.slave   bus
);
    localparam int W  = MAN_W + 5;
    localparam int XW = EXP_W + 2;
    localparam int DW = $clog2(W) + 1;
    localparam int RW = 1 + EXP_W + MAN_W;
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    // Stage enables: a stage loads when empty or when its successor is taking its beat.
    logic s1_en, s2_en, s3_en;
    logic s1_v_q, s2_v_q, s3_v_q;

    assign s3_en        = !s3_v_q || bus.out_ready;
    assign s2_en        = !s2_v_q || s3_en;
    assign s1_en        = !s1_v_q || s2_en;
    assign bus.in_ready = s1_en;

    // ---------------- S1: leading-one detect ----------------
    logic            s1_sign_q, s1_zero_q;
    logic [1:0]      s1_mode_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [W-1:0]    s1_frac_q;
    logic [DW-1:0]   s1_lz_q, lz_d;

    always_comb begin
        lz_d = '0;
        for (int i = 0; i <= W - 2; i++) begin
            if (bus.in_frac[i]) lz_d = DW'(W - 2 - i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_mode_q <= '0;
            s1_exp_q  <= '0;
            s1_frac_q <= '0;
            s1_lz_q   <= '0;
        end else if (s1_en) begin
            s1_v_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_q <= bus.in_sign;
                s1_zero_q <= (bus.in_frac == '0);
                s1_mode_q <= bus.rnd_mode;
                s1_exp_q  <= bus.in_exp;
                s1_frac_q <= bus.in_frac;
                s1_lz_q   <= lz_d;
            end
        end
    end

    // ---------------- S2: shift and exponent adjust ----------------
    logic                   s2_sign_q, s2_zero_q, s2_tiny_q, s2_tiny_d;
    logic [1:0]             s2_mode_q;
    logic signed [XW-1:0]   s2_exp_q, s2_exp_d, exp_in, lz_x;
    logic [W-2:0]           s2_mant_q, s2_mant_d;

    // The carry bit is dropped from S2 onward: after normalising it is always zero.
    always_comb begin
        s2_mant_d = '0;
        s2_exp_d  = '0;
        s2_tiny_d = 1'b0;
        exp_in    = XW'(s1_exp_q);
        lz_x      = XW'(s1_lz_q);
        if (s1_zero_q) begin
            s2_mant_d = '0;
        end else if (s1_frac_q[W-1]) begin
            s2_mant_d = {s1_frac_q[W-1:2], s1_frac_q[1] | s1_frac_q[0]};
            s2_exp_d  = exp_in + XW'(1);
        end else if (exp_in > lz_x) begin
            s2_mant_d = s1_frac_q[W-2:0] << s1_lz_q;
            s2_exp_d  = exp_in - lz_x;
        end else begin
            // Gradual underflow: stop shifting once the exponent would hit the denormal floor.
            s2_mant_d = s1_frac_q[W-2:0] << (s1_exp_q - 1'b1);
            s2_exp_d  = '0;
            s2_tiny_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q    <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_tiny_q <= 1'b0;
            s2_mode_q <= '0;
            s2_exp_q  <= '0;
            s2_mant_q <= '0;
        end else if (s2_en) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_sign_q <= s1_sign_q;
                s2_zero_q <= s1_zero_q;
                s2_tiny_q <= s2_tiny_d;
                s2_mode_q <= s1_mode_q;
                s2_exp_q  <= s2_exp_d;
                s2_mant_q <= s2_mant_d;
            end
        end
    end

    // ---------------- S3: round, renormalise, pack ----------------
    logic [MAN_W:0]         sig;
    logic [MAN_W+1:0]       sig_r;
    logic                   g_b, r_b, s_b, inc, inexact, to_inf, mag_zero;
    logic signed [XW-1:0]   exp_r;
    logic [RW-1:0]          res_d, res_q;
    logic [3:0]             flags_d, flags_q;

    always_comb begin
        sig      = s2_mant_q[W-2:3];
        g_b      = s2_mant_q[2];
        r_b      = s2_mant_q[1];
        s_b      = s2_mant_q[0];
        inexact  = g_b || r_b || s_b;
        inc      = 1'b0;
        to_inf   = 1'b0;
        mag_zero = 1'b0;
        res_d    = '0;
        flags_d  = '0;
        case (s2_mode_q)
            2'b00:   inc = g_b && (r_b || s_b || sig[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = !s2_sign_q && inexact;
            default: inc = s2_sign_q && inexact;
        endcase
        sig_r = {1'b0, sig} + {{(MAN_W+1){1'b0}}, inc};
        exp_r = s2_exp_q + {{(XW-1){1'b0}}, sig_r[MAN_W+1]};
        // A denormal that rounds up into the hidden bit becomes the smallest normal.
        if (s2_exp_q == '0 && sig_r[MAN_W]) exp_r = XW'(1);

        if (s2_zero_q) begin
            res_d   = {(s2_mode_q == 2'b11), {(EXP_W+MAN_W){1'b0}}};
            flags_d = 4'b0001;
        end else if (exp_r >= EXP_MAX) begin
            to_inf = (s2_mode_q == 2'b00) ||
                     (s2_mode_q == 2'b10 && !s2_sign_q) ||
                     (s2_mode_q == 2'b11 && s2_sign_q);
            res_d  = to_inf ? {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                            : {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            flags_d = 4'b1010;
        end else begin
            mag_zero = (exp_r == '0) && (sig_r[MAN_W-1:0] == '0);
            res_d    = {s2_sign_q, exp_r[EXP_W-1:0], sig_r[MAN_W-1:0]};
            flags_d  = {1'b0, s2_tiny_q && inexact, inexact, mag_zero};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_v_q  <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else if (s3_en) begin
            s3_v_q <= s2_v_q;
            if (s2_v_q) begin
                res_q   <= res_d;
                flags_q <= flags_d;
            end
        end
    end

    assign bus.out_valid  = s3_v_q;
    assign bus.out_result = res_q;
    assign bus.out_flags  = flags_q;
endmodule

// File: tb/tb_norm_round_pipe.sv
// Scoreboarded bench for norm_round_pipe: directed IEEE cases, backpressure,
// mid-stream reset and randomized traffic against a value-level rounding model.
module tb_norm_round_pipe;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = MAN_W + 5;
  localparam int RW    = 1 + EXP_W + MAN_W;
  localparam int EW    = RW + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int rdy_mode = 1;  // 0: hold off, 1: always ready, 2: random
  logic [EW-1:0] exp_q[$];
  int lat_q[$];

  norm_round_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  norm_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Treats in_frac as an exact integer scaled by in_exp, picks the result exponent
  // from the most significant one, clamps it at the denormal floor and rounds the
  // discarded tail with the selected mode.
  function automatic logic [EW-1:0] ref_model(input logic s, input logic [EXP_W-1:0] ex,
                                              input logic [W-1:0] f, input logic [1:0] m);
    int p, e, h, sh, fld;
    logic [63:0] v, sig;
    bit g, r, st, inc, tiny, inex, to_inf;
    logic [RW-1:0] res;
    logic [3:0] fl;
    if (f == '0) return {4'b0001, (m == 2'b11), {(RW-1){1'b0}}};
    p = 0;
    for (int i = 0; i < W; i++) if (f[i]) p = i;
    e = int'(ex) + p - (W - 2);
    tiny = (e < 1);
    if (tiny) e = 1;
    h = (W - 2) + e - int'(ex);  // bit of f that lands on the hidden position
    v = 64'(f);
    g = 0; r = 0; st = 0;
    if (h >= MAN_W) begin
      sh = h - MAN_W;
      sig = v >> sh;
      if (sh >= 1) g = v[sh-1];
      if (sh >= 2) r = v[sh-2];
      if (sh >= 3) st = (v & ((64'd1 << (sh - 2)) - 64'd1)) != 64'd0;
    end else begin
      sig = v << (MAN_W - h);
    end
    inex = g || r || st;
    case (m)
      2'b00:   inc = g && (r || st || sig[0]);
      2'b01:   inc = 0;
      2'b10:   inc = !s && inex;
      default: inc = s && inex;
    endcase
    sig = sig + 64'(inc);
    if (sig >= (64'd1 << (MAN_W + 1))) begin
      sig = sig >> 1;
      e = e + 1;
    end
    if (tiny) fld = (sig >= (64'd1 << MAN_W)) ? 1 : 0;
    else fld = e;
    if (fld >= (1 << EXP_W) - 1) begin
      to_inf = (m == 2'b00) || (m == 2'b10 && !s) || (m == 2'b11 && s);
      res = to_inf ? {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                   : {s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      fl = 4'b1010;
    end else begin
      res = {s, EXP_W'(fld), sig[MAN_W-1:0]};
      fl = {1'b0, tiny && inex, inex, (fld == 0) && (sig[MAN_W-1:0] == '0)};
    end
    return {fl, res};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at a negedge with in_valid still high.
  task automatic send(input logic s, input logic [EXP_W-1:0] e, input logic [W-1:0] f,
                      input logic [1:0] m, input bit lat);
    int budget;
    bit done;
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_frac  = f;
    bus.rnd_mode = m;
    budget = 0;
    done = 0;
    while (!done) begin
      #4;
      if (bus.in_ready) begin
        exp_q.push_back(ref_model(s, e, f, m));
        lat_q.push_back(lat ? cyc : -1);
        done = 1;
      end else if (budget >= 300) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected acceptance", budget);
        done = 1;
      end
      budget++;
      @(negedge clk);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  function automatic logic [W-1:0] rand_frac();
    logic [W-1:0] f;
    int k;
    k = $urandom_range(0, 9);
    f = W'({$urandom, $urandom});
    case (k)
      0: f = '0;
      1: f[W-1] = 1'b1;
      2, 3: begin f[W-1] = 1'b0; f[W-2] = 1'b1; end
      4, 5, 6, 7: begin f[W-1] = 1'b0; f = f >> $urandom_range(1, W - 1); end
      8: f = {1'b0, {(W-1){1'b1}}};
      default: f[W-1] = 1'b0;
    endcase
    return f;
  endfunction

  function automatic logic [EXP_W-1:0] rand_exp();
    case ($urandom_range(0, 6))
      0: return EXP_W'(1);
      1: return EXP_W'(2);
      2: return EXP_W'(3);
      3: return EXP_W'(253);
      4: return EXP_W'(254);
      default: return EXP_W'($urandom_range(1, 254));
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [EW-1:0] e;
    int l;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0: bus.out_ready = 1'b0;
        1: bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      #4;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h, expected no output", bus.out_result);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          check("result", 64'(bus.out_result), 64'(e[RW-1:0]));
          check("flags", 64'(bus.out_flags), 64'(e[EW-1:RW]));
          if (l >= 0) check("latency", 64'(cyc - l), 64'd3);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic [W-1:0] bf[5];
    logic [EXP_W-1:0] be[5];
    logic bs[5];
    logic [1:0] bm[5];
    logic [EW-1:0] m1;

    bus.in_valid = 1'b0;
    bus.in_sign  = 1'b0;
    bus.in_exp   = '0;
    bus.in_frac  = '0;
    bus.rnd_mode = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_result", 64'(bus.out_result), 64'd0);
    check("rst_out_flags", 64'(bus.out_flags), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases; the first one also checks the 3-cycle latency.
    send(1'b0, 8'd127, 28'h8000000, 2'b00, 1);                 // 1.0 + 1.0
    idle();
    repeat (4) @(negedge clk);
    send(1'b0, 8'd127, 28'h1000000, 2'b00, 0);                 // cancellation -> 0.25
    send(1'b0, 8'd127, 28'h400000C, 2'b00, 0);                 // RNE tie, odd lsb
    send(1'b0, 8'd127, 28'h4000014, 2'b00, 0);                 // RNE tie, even lsb
    send(1'b0, 8'd127, 28'h400000C, 2'b01, 0);                 // RTZ
    send(1'b0, 8'd254, 28'h8000000, 2'b00, 0);                 // overflow RNE -> inf
    send(1'b0, 8'd254, 28'h8000000, 2'b01, 0);                 // overflow RTZ -> max
    send(1'b0, 8'd254, 28'h8000000, 2'b11, 0);                 // overflow -inf, positive
    send(1'b1, 8'd254, 28'h8000000, 2'b11, 0);                 // overflow -inf, negative
    send(1'b0, 8'd3,   28'h0200000, 2'b00, 0);                 // denormal, exact
    send(1'b0, 8'd1,   28'h0200002, 2'b00, 0);                 // denormal, inexact
    send(1'b0, 8'd1,   28'h3FFFFFF, 2'b00, 0);                 // denormal rounds to min normal
    send(1'b1, 8'd100, 28'h0000000, 2'b11, 0);                 // zero, mode 11
    send(1'b1, 8'd100, 28'h0000000, 2'b00, 0);                 // zero, RNE
    send(1'b1, 8'd127, 28'h4000001, 2'b11, 0);                 // -inf directed on negative
    send(1'b0, 8'd200, 28'h7FFFFFF, 2'b10, 0);                 // round carry-out, +inf
    idle();
    drain();

    // Backpressure: three beats fill the pipe, the fourth must be refused.
    for (int i = 0; i < 5; i++) begin
      bs[i] = 1'($urandom_range(0, 1));
      be[i] = rand_exp();
      bf[i] = rand_frac();
      bm[i] = 2'($urandom_range(0, 3));
    end
    m1 = ref_model(bs[0], be[0], bf[0], bm[0]);
    rdy_mode = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) send(bs[i], be[i], bf[i], bm[i], 0);
    bus.in_sign  = bs[3];
    bus.in_exp   = be[3];
    bus.in_frac  = bf[3];
    bus.rnd_mode = bm[3];
    repeat (5) begin
      #4;
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_hold_result", 64'(bus.out_result), 64'(m1[RW-1:0]));
      check("bp_hold_flags", 64'(bus.out_flags), 64'(m1[EW-1:RW]));
      @(negedge clk);
    end
    rdy_mode = 1;
    send(bs[3], be[3], bf[3], bm[3], 0);
    send(bs[4], be[4], bf[4], bm[4], 0);
    idle();
    drain();

    // Mid-stream reset discards in-flight beats.
    rdy_mode = 0;
    @(negedge clk);
    send(1'b0, rand_exp(), rand_frac(), 2'b00, 0);
    send(1'b1, rand_exp(), rand_frac(), 2'b01, 0);
    idle();
    repeat (3) @(negedge clk);
    check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("post_rst_out_result", 64'(bus.out_result), 64'd0);
    check("post_rst_out_flags", 64'(bus.out_flags), 64'd0);
    rdy_mode = 1;
    repeat (8) @(negedge clk);

    // Randomized traffic with random backpressure and input gaps.
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send(1'($urandom_range(0, 1)), rand_exp(), rand_frac(), 2'($urandom_range(0, 3)), 0);
    end
    idle();
    rdy_mode = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
